// File: rtl/estimate_array_if.sv
// Command/parameter bus for estimate_array.
// The master drives commands and parameter writes. The slave returns the handshake and activations.
interface estimate_array_if #(
    parameter int LANES = 32,
    parameter int DW    = 32,
    parameter int AW    = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd;
    logic [AW-1:0]         addr;
    logic [DW-1:0]         data;
    logic                  prm_we;
    logic [AW-1:0]         prm_addr;
    logic [LANES*DW-1:0]   prm_wdata;
    logic [LANES-1:0]      activ;
    logic                  activ_valid;

    modport master (
        output cmd_valid, cmd, addr, data, prm_we, prm_addr, prm_wdata,
        input  cmd_ready, activ, activ_valid
    );

    modport slave (
        input  cmd_valid, cmd, addr, data, prm_we, prm_addr, prm_wdata,
        output cmd_ready, activ, activ_valid
    );
endinterface

// File: rtl/estimate_array.sv
// estimate_array: LANES-wide binarized/8-bit CNN inference array.
// It has a three-edge pipeline:
//   - accept / RAM read;
//   - per-lane operand;
//   - acc/pool/activ update.
// Define ESTIMATE_ACC8_EN to enable the 8-bit ACC8/NORM8 opcodes.
// When the macro is not defined, those opcodes are NOPs and no multipliers are built.

module estimate_lane #(
    parameter int DW   = 32,
    parameter int ACCW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      i_s1_cmd,
    input  logic [DW-1:0]   i_s1_data,
    input  logic [DW-1:0]   i_p,
    input  logic            i_s2_vld,
    input  logic [2:0]      i_s2_cmd,
    input  logic [ACCW-1:0] i_s2_d,
    output logic            o_activ
);
    localparam int SW = ACCW + $clog2(DW) + 2;
    localparam logic [ACCW-1:0] MINV = {1'b1, {(ACCW-1){1'b0}}};
    localparam logic [2:0] OP_INI = 3'd0, OP_ACC = 3'd1, OP_POOL = 3'd2, OP_NORM = 3'd3,
                           OP_ACTIV = 3'd4, OP_ACC8 = 3'd5, OP_NORM8 = 3'd6;

    logic [DW-1:0]          w_xnor;
    logic [SW-1:0]          w_pc2;
    logic signed [SW-1:0]   w_add8;
    logic signed [SW-1:0]   r_add;
    logic [ACCW-1:0]        r_p;
    logic [ACCW-1:0]        r_acc;
    logic [ACCW-1:0]        r_pool;
    logic                   r_activ;
    logic [SW-1:0]          w_sum;
    logic [ACCW-1:0]        w_sat;

    assign w_xnor = ~(i_s1_data ^ i_p);

    // Twice the XNOR popcount (the +1/-1 dot product shifted into the non-negative range)
    always_comb begin
        w_pc2 = '0;
        for (int i = 0; i < DW; i++) w_pc2 = w_pc2 + SW'(w_xnor[i]);
        w_pc2 = w_pc2 << 1;
    end

`ifdef ESTIMATE_ACC8_EN
    logic signed [SW-1:0] w_dot;
    // Signed byte-wise dot product summed at full width, halved arithmetically afterwards
    always_comb begin
        logic signed [15:0] v_prod;
        v_prod = '0;
        w_dot  = '0;
        for (int k = 0; k < DW/8; k++) begin
            v_prod = $signed(i_s1_data[8*k +: 8]) * $signed(i_p[8*k +: 8]);
            w_dot  = w_dot + {{(SW-16){v_prod[15]}}, v_prod};
        end
    end
    assign w_add8 = w_dot >>> 1;
`else
    assign w_add8 = '0;
`endif

    // Stage-2 operand: ACC/ACC8 addend plus the low parameter bits used by NORM/NORM8
    always_ff @(posedge clk) begin
        r_add <= (i_s1_cmd == OP_ACC8) ? w_add8 : w_pc2;
        r_p   <= i_p[ACCW-1:0];
    end

    assign w_sum = {{(SW-ACCW){r_acc[ACCW-1]}}, r_acc} + r_add;

    // Clamp to the signed ACCW range: the sum is out of range unless the top bits are pure sign copies
    always_comb begin
        w_sat = w_sum[ACCW-1:0];
        if (w_sum[SW-1:ACCW-1] != {(SW-ACCW+1){w_sum[SW-1]}})
            w_sat = w_sum[SW-1] ? MINV : ~MINV;
    end

    // Architectural lane state. It reads its own registers, so back-to-back commands chain naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_pool  <= MINV;
            r_activ <= 1'b0;
        end else if (i_s2_vld) begin
            case (i_s2_cmd)
                OP_INI: begin
                    r_acc  <= i_s2_d;
                    r_pool <= MINV;
                end
                OP_ACC:   r_acc <= w_sat;
                OP_POOL: begin
                    if ($signed(r_acc) >= $signed(r_pool)) r_pool <= r_acc;
                    r_acc <= i_s2_d;
                end
                OP_NORM:  r_pool  <= (r_pool << 3) - r_p;
                OP_ACTIV: r_activ <= r_pool[ACCW-1];
`ifdef ESTIMATE_ACC8_EN
                OP_ACC8:  r_acc  <= w_sat;
                OP_NORM8: r_pool <= r_pool - r_p;
`endif
                default: ;
            endcase
        end
    end

    assign o_activ = r_activ;
endmodule

module estimate_array #(
    parameter int LANES = 32,
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter int DEPTH = 1024,
    parameter int ACCW  = 16
) (
    input logic              clk,
    input logic              reset,
    estimate_array_if.slave  bus
);
    localparam int STAGES = 2;
    localparam logic [2:0] OP_ACTIV = 3'd4;

    logic                  w_ready;
    logic                  w_accept;
    logic [STAGES:1]       r_vld_pipe;
    logic [2:0]            r_s1_cmd;
    logic [DW-1:0]         r_s1_data;
    logic [2:0]            r_s2_cmd;
    logic [ACCW-1:0]       r_s2_d;
    logic [LANES*DW-1:0]   r_mem [DEPTH];
    logic [LANES*DW-1:0]   r_rd;
    logic                  r_activ_valid;
    logic [LANES-1:0]      w_activ;

    // A parameter write blocks command acceptance, so a read and a write never collide.
    assign w_ready       = !reset && !bus.prm_we;
    assign w_accept      = bus.cmd_valid && w_ready;
    assign bus.cmd_ready = w_ready;

    // Parameter RAM with a registered read. Reset leaves the contents alone.
    always_ff @(posedge clk) begin
        if (bus.prm_we) r_mem[bus.prm_addr] <= bus.prm_wdata;
        r_rd <= r_mem[bus.addr];
    end

    // Valid shift register and broadcast command/data pipeline; activ_valid trails the final stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_pipe    <= '0;
            r_activ_valid <= 1'b0;
        end else begin
            r_vld_pipe    <= {r_vld_pipe[STAGES-1:1], w_accept};
            r_activ_valid <= r_vld_pipe[STAGES] && (r_s2_cmd == OP_ACTIV);
        end
        r_s1_cmd  <= bus.cmd;
        r_s1_data <= bus.data;
        r_s2_cmd  <= r_s1_cmd;
        r_s2_d    <= r_s1_data[ACCW-1:0];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        estimate_lane #(.DW(DW), .ACCW(ACCW)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .i_s1_cmd  (r_s1_cmd),
            .i_s1_data (r_s1_data),
            .i_p       (r_rd[DW*(LANES-1-g) +: DW]),
            .i_s2_vld  (r_vld_pipe[STAGES]),
            .i_s2_cmd  (r_s2_cmd),
            .i_s2_d    (r_s2_d),
            .o_activ   (w_activ[g])
        );
    end

    assign bus.activ       = w_activ;
    assign bus.activ_valid = r_activ_valid;
endmodule

// File: tb/tb_estimate_array.sv
// Self-checking bench for estimate_array.
// It runs directed scenarios followed by randomized traffic.
// The checks compare the outputs against a sequential per-lane model.
// That model applies each command at acceptance time.
// The bench then schedules the activation strobe two edges after the accepting edge.
module tb_estimate_array;
    localparam int LANES = 32, DW = 32, AW = 10, DEPTH = 1024, ACCW = 16;
    localparam int WW = LANES*DW;
    localparam logic [2:0] INI = 3'd0, ACC = 3'd1, POOL = 3'd2, NORM = 3'd3,
                           ACTIV = 3'd4, ACC8 = 3'd5, NOP = 3'd7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    estimate_array_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus ();
    estimate_array #(.LANES(LANES), .DW(DW), .AW(AW), .DEPTH(DEPTH), .ACCW(ACCW)) dut (
        .clk(clk), .reset(rst), .bus(bus)
    );

    typedef struct { int due; logic [LANES-1:0] val; } ev_t;

    int               n_chk = 0, n_fail = 0, edge_n = 0;
    int               m_acc [LANES];
    int               m_pool [LANES];
    logic [WW-1:0]    m_mem [int];
    logic [LANES-1:0] cur_activ = '0;
    ev_t              evq [$];

    task automatic chk(string tag, logic [LANES-1:0] obs, logic [LANES-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int wrapw(int v);
        int t;
        t = v & ((1 << ACCW) - 1);
        if (t >= (1 << (ACCW-1))) t -= (1 << ACCW);
        return t;
    endfunction

    function automatic int satw(int v);
        if (v > (1 << (ACCW-1)) - 1) return (1 << (ACCW-1)) - 1;
        if (v < -(1 << (ACCW-1)))    return -(1 << (ACCW-1));
        return v;
    endfunction

    function automatic logic [WW-1:0] rep(logic [DW-1:0] v);
        logic [WW-1:0] r;
        for (int g = 0; g < LANES; g++) r[DW*g +: DW] = v;
        return r;
    endfunction

    function automatic logic [WW-1:0] rnd_word();
        logic [WW-1:0] r;
        for (int i = 0; i < WW/32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < LANES; g++) begin
            m_acc[g]  = 0;
            m_pool[g] = -(1 << (ACCW-1));
        end
        cur_activ = '0;
        evq.delete();
    endtask

    task automatic model_exec(logic [2:0] op, logic [AW-1:0] a, logic [DW-1:0] d);
        logic [WW-1:0]    w;
        logic [DW-1:0]    p;
        logic [LANES-1:0] v;
        int               s;
        w = m_mem.exists(int'(a)) ? m_mem[int'(a)] : '0;
        v = '0;
        for (int g = 0; g < LANES; g++) begin
            p = w[DW*(LANES-1-g) +: DW];
            case (op)
                INI:   begin m_acc[g] = wrapw(int'(d[ACCW-1:0])); m_pool[g] = -(1 << (ACCW-1)); end
                ACC:   m_acc[g] = satw(m_acc[g] + 2*$countones(~(d ^ p)));
                POOL:  begin
                    if (m_acc[g] >= m_pool[g]) m_pool[g] = m_acc[g];
                    m_acc[g] = wrapw(int'(d[ACCW-1:0]));
                end
                NORM:  m_pool[g] = wrapw(m_pool[g]*8 - int'(p[ACCW-1:0]));
                ACTIV: v[g] = (m_pool[g] < 0);
`ifdef ESTIMATE_ACC8_EN
                ACC8:  begin
                    s = 0;
                    for (int k = 0; k < DW/8; k++)
                        s += int'($signed(d[8*k +: 8])) * int'($signed(p[8*k +: 8]));
                    m_acc[g] = satw(m_acc[g] + (s >>> 1));
                end
                3'd6:  m_pool[g] = wrapw(m_pool[g] - int'(p[ACCW-1:0]));
`endif
                default: ;
            endcase
        end
        if (op == ACTIV) evq.push_back('{edge_n + 2, v});
    endtask

    // One clock. Inputs are held from the previous call.
    // cmd_ready is checked mid-cycle; activ/activ_valid are checked 1ns after the edge.
    task automatic tick();
        logic exp_rdy, took, exp_av;
        @(negedge clk);
        exp_rdy = !rst && !bus.prm_we;
        chk("cmd_ready", bus.cmd_ready, exp_rdy);
        took = bus.cmd_valid && exp_rdy;
        @(posedge clk);
        edge_n++;
        if (rst) model_reset();
        else if (took) model_exec(bus.cmd, bus.addr, bus.data);
        if (bus.prm_we) m_mem[int'(bus.prm_addr)] = bus.prm_wdata;
        #1;
        exp_av = 1'b0;
        if (evq.size() > 0 && evq[0].due == edge_n) begin
            exp_av    = 1'b1;
            cur_activ = evq[0].val;
            void'(evq.pop_front());
        end
        chk("activ_valid", bus.activ_valid, exp_av);
        chk("activ", bus.activ, cur_activ);
    endtask

    task automatic cmd(logic [2:0] c, logic [AW-1:0] a, logic [DW-1:0] d);
        bus.cmd_valid = 1'b1; bus.cmd = c; bus.addr = a; bus.data = d;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic idle(int n);
        bus.cmd_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(int a, logic [WW-1:0] w);
        bus.prm_we = 1'b1; bus.prm_addr = AW'(a); bus.prm_wdata = w;
        tick();
        bus.prm_we = 1'b0;
    endtask

    initial begin
        logic [WW-1:0]    w;
        logic [LANES-1:0] exp8;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd = NOP; bus.addr = '0; bus.data = '0;
        bus.prm_we = 1'b0; bus.prm_addr = '0; bus.prm_wdata = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_activ", bus.activ, '0);
        chk("rst_av", bus.activ_valid, 1'b0);
        rst = 1'b0;

        for (int a = 0; a < 16; a++) wr(a, rnd_word());
        wr(3, rep(32'hFFFF_0000));
        wr(4, rep(32'd257));
        wr(5, rep(32'd0));
        wr(6, rep(32'd0));
        w = rep(32'd0); w[DW*(LANES-1) +: DW] = '1; wr(7, w);
        w = rep(32'd1); w[DW*(LANES-1) +: DW] = 32'd8; wr(8, w);
        wr(9, rep(32'hFFFF_FFFF));

        // Basic chain: pool = 32. The strobe must appear exactly two edges after the accepting edge.
        cmd(INI, 0, 0); cmd(ACC, 3, 32'hFFFF_FFFF); cmd(POOL, 0, 0); cmd(ACTIV, 0, 0);
        idle(1); chk("t1_av_early", bus.activ_valid, 1'b0);
        idle(1); chk("t1_av", bus.activ_valid, 1'b1); chk("t1_activ", bus.activ, '0);
        // A probe of 256 - 257 turns negative only if pool was exactly 32.
        cmd(NORM, 4, 0); cmd(ACTIV, 0, 0); idle(3);
        chk("t1_pool32", bus.activ, '1);

        // Saturation: 0x7FF0 + 64 clamps to 0x7FFF. The probe 0x7FFF*8 wraps to -8.
        cmd(INI, 0, 32'h7FF0); cmd(ACC, 3, 32'hFFFF_0000); cmd(POOL, 0, 0); cmd(ACTIV, 0, 0);
        idle(3); chk("t2_sat_activ", bus.activ, '0);
        cmd(NORM, 5, 0); cmd(ACTIV, 0, 0); idle(3);
        chk("t2_sat_probe", bus.activ, '1);

        // A write cycle blocks the command. The following read sees the new word.
        cmd(INI, 0, 0); cmd(POOL, 0, 0);
        bus.prm_we = 1'b1; bus.prm_addr = AW'(6); bus.prm_wdata = rep(32'd1);
        bus.cmd_valid = 1'b1; bus.cmd = ACTIV;
        #1 chk("t3_rdy", bus.cmd_ready, 1'b0);
        tick();
        bus.prm_we = 1'b0; bus.cmd_valid = 1'b0;
        cmd(NORM, 6, 0); cmd(ACTIV, 0, 0); idle(3);
        chk("t3_newword", bus.activ, '1);

        // Lane mapping: lane 0 owns the most-significant parameter slice.
        cmd(INI, 0, 0); cmd(ACC, 7, 32'hFFFF_FFFF); cmd(POOL, 0, 0); cmd(NORM, 8, 0);
        cmd(ACTIV, 0, 0); idle(3);
        chk("t4_lanes", bus.activ, 32'hFFFF_FFFE);

        // Reset with commands in flight discards them all.
        cmd(INI, 0, 0); cmd(ACTIV, 0, 0); cmd(ACTIV, 0, 0);
        rst = 1'b1; bus.cmd_valid = 1'b1; bus.cmd = ACTIV;
        tick();
        chk("t5_av", bus.activ_valid, 1'b0); chk("t5_activ", bus.activ, '0);
        tick();
        rst = 1'b0; bus.cmd_valid = 1'b0;
        idle(2);
        chk("t5_av_post", bus.activ_valid, 1'b0); chk("t5_activ_post", bus.activ, '0);
        cmd(ACTIV, 0, 0); idle(3); chk("t5_pool_min", bus.activ, '1);
        cmd(POOL, 0, 0); cmd(ACTIV, 0, 0); idle(3); chk("t5_acc_zero", bus.activ, '0);

        // ACC8: four bytes of 2 * (-1) give a sum of -8, halved to -4.
`ifdef ESTIMATE_ACC8_EN
        exp8 = '1;
`else
        exp8 = '0;
`endif
        cmd(INI, 0, 0); cmd(ACC8, 9, 32'h0202_0202); cmd(POOL, 0, 0); cmd(ACTIV, 0, 0);
        idle(3); chk("t6_acc8", bus.activ, exp8);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.prm_we    = ($urandom_range(0, 9) == 0);
            bus.prm_addr  = AW'($urandom_range(0, 15));
            bus.prm_wdata = rnd_word();
            bus.cmd_valid = ($urandom_range(0, 6) != 0);
            bus.cmd       = 3'($urandom_range(0, 7));
            bus.addr      = AW'($urandom_range(0, 15));
            bus.data      = $urandom;
            if ($urandom_range(0, 3) == 0) bus.data[15:8] = $urandom_range(0, 1) ? 8'h7F : 8'h80;
            tick();
        end
        rst = 1'b0; bus.prm_we = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
